// File: rtl/calc_pkg.sv
// calc_pkg: shared constants for the BCD calculator keypad sequencer.
// Key codes, ALU operation encodings, sequencer states and a digit-count helper.
package calc_pkg;

  localparam int DIGIT_NUM_DEF = 8;

  localparam logic [4:0] KEY_DP   = 5'd10;
  localparam logic [4:0] KEY_NEG  = 5'd11;
  localparam logic [4:0] KEY_ADD  = 5'd12;
  localparam logic [4:0] KEY_SUB  = 5'd13;
  localparam logic [4:0] KEY_MUL  = 5'd14;
  localparam logic [4:0] KEY_DIV  = 5'd15;
  localparam logic [4:0] KEY_POW  = 5'd16;
  localparam logic [4:0] KEY_EQ   = 5'd17;
  localparam logic [4:0] KEY_CLR  = 5'd18;
  localparam logic [4:0] KEY_BKSP = 5'd19;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_POW = 3'd4;

  typedef enum logic [1:0] {
    ST_ENTER_A = 2'd0,
    ST_ENTER_B = 2'd1,
    ST_EXEC    = 2'd2,
    ST_SHOW    = 2'd3
  } state_t;

  // Number of significant BCD digits in the low n nibbles of v (leading zeros excluded).
  function automatic int sig_digits(input logic [63:0] v, input int n);
    int c;
    c = 0;
    for (int i = 0; i < 16; i++) begin
      if (i < n && v[i*4 +: 4] != 4'd0) c = i + 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/calc_entry_reg.sv
// calc_entry_reg: one BCD operand entry (digits, count, decimal point, sign).
// A clear or load selects the base value; key actions are then applied on top,
// so "start a fresh entry and apply this key" is a single-cycle operation.
// Optional backspace is compiled in with CALC_BACKSPACE_EN.
module calc_entry_reg
  import calc_pkg::*;
#(
  parameter int DIGIT_NUM = DIGIT_NUM_DEF,
  parameter int DP_W      = 4,
  parameter int DP_MAX    = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   ld,
  input  logic [DIGIT_NUM*4-1:0] ld_digits,
  input  logic                   ld_sign,
  input  logic                   key_digit,
  input  logic [3:0]             digit,
  input  logic                   key_dp,
  input  logic                   key_neg,
`ifdef CALC_BACKSPACE_EN
  input  logic                   key_bksp,
`endif
  output logic [DIGIT_NUM*4-1:0] digits,
  output logic                   sign,
  output logic [DP_W-1:0]        dp,
  output logic                   has,
  output logic [DIGIT_NUM*4-1:0] digits_nxt,
  output logic                   sign_nxt,
  output logic [DP_W-1:0]        dp_nxt,
  output logic                   has_nxt
);

  localparam int W     = DIGIT_NUM * 4;
  localparam int CNT_W = $clog2(DIGIT_NUM + 1);

  logic [CNT_W-1:0] cnt, cnt_nxt, b_cnt;
  logic             dp_seen, dp_seen_nxt, b_dp_seen;
  logic [W-1:0]     b_digits;
  logic [DP_W-1:0]  b_dp;
  logic             b_sign, b_has;

  // Base value selection, then the key action applied to it.
  always_comb begin
    b_digits  = digits;
    b_cnt     = cnt;
    b_dp_seen = dp_seen;
    b_dp      = dp;
    b_sign    = sign;
    b_has     = has;
    if (clr) begin
      b_digits  = '0;
      b_cnt     = '0;
      b_dp_seen = 1'b0;
      b_dp      = '0;
      b_sign    = 1'b0;
      b_has     = 1'b0;
    end else if (ld) begin
      b_digits  = ld_digits;
      b_cnt     = CNT_W'(sig_digits(64'(ld_digits), DIGIT_NUM));
      b_dp_seen = 1'b0;
      b_dp      = '0;
      b_sign    = ld_sign;
      b_has     = 1'b1;
    end
    digits_nxt  = b_digits;
    cnt_nxt     = b_cnt;
    dp_seen_nxt = b_dp_seen;
    dp_nxt      = b_dp;
    sign_nxt    = b_sign;
    has_nxt     = b_has;
    if (key_digit) begin
      has_nxt = 1'b1;
      // Full entry, saturated fraction, or a leading zero leaves the value alone.
      if (b_cnt != CNT_W'(DIGIT_NUM) && !(b_dp_seen && b_dp == DP_W'(DP_MAX)) &&
          (b_cnt != '0 || digit != 4'd0 || b_dp_seen)) begin
        digits_nxt = {b_digits[W-5:0], digit};
        cnt_nxt    = b_cnt + CNT_W'(1);
        if (b_dp_seen) dp_nxt = b_dp + DP_W'(1);
      end
    end
    if (key_dp) begin
      has_nxt     = 1'b1;
      dp_seen_nxt = 1'b1;
    end
    if (key_neg) sign_nxt = !b_sign;
`ifdef CALC_BACKSPACE_EN
    if (key_bksp) begin
      // A bare decimal point is removed before any integer digit.
      if (b_dp_seen && b_dp == '0) begin
        dp_seen_nxt = 1'b0;
      end else if (b_cnt != '0) begin
        digits_nxt = {4'd0, b_digits[W-1:4]};
        cnt_nxt    = b_cnt - CNT_W'(1);
        if (b_dp != '0) dp_nxt = b_dp - DP_W'(1);
      end
    end
`endif
  end

  // Entry state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits  <= '0;
      cnt     <= '0;
      dp_seen <= 1'b0;
      dp      <= '0;
      sign    <= 1'b0;
      has     <= 1'b0;
    end else begin
      digits  <= digits_nxt;
      cnt     <= cnt_nxt;
      dp_seen <= dp_seen_nxt;
      dp      <= dp_nxt;
      sign    <= sign_nxt;
      has     <= has_nxt;
    end
  end

endmodule

// File: rtl/calc_seq_ctrl.sv
// calc_seq_ctrl: keypad sequencer for the 8-digit BCD calculator ALU.
// Builds operands A and B from key events, runs the ALU for ALU_LAT cycles,
// captures the result and drives registered display outputs.
// Backspace (key code 19) is enabled with the CALC_BACKSPACE_EN macro.
module calc_seq_ctrl
  import calc_pkg::*;
#(
  parameter int DIGIT_NUM = DIGIT_NUM_DEF,
  parameter int ALU_LAT   = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   key_valid,
  input  logic [4:0]             key_code,
  output logic                   key_ready,
  output logic                   operand0_sign,
  output logic [DIGIT_NUM*4-1:0] operand0,
  output logic [3:0]             operand0_dp,
  output logic                   operand1_sign,
  output logic [DIGIT_NUM*4-1:0] operand1,
  output logic [2:0]             operand1_dp,
  output logic [2:0]             operation,
  input  logic [DIGIT_NUM*4-1:0] alu_result,
  input  logic                   alu_result_sign,
  output logic [DIGIT_NUM*4-1:0] disp_bcd,
  output logic                   disp_sign,
  output logic [3:0]             disp_dp,
  output logic                   busy,
  output logic                   err
);

  localparam int W  = DIGIT_NUM * 4;
  localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  state_t          state_q, state_d;
  logic [2:0]      op_d, pend_op_q, pend_op_d;
  logic            pend_q, pend_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    res_q, res_d;
  logic            res_sign_q, res_sign_d, err_d;
  logic            a_clr, a_ld, a_dig, a_dp, a_neg;
  logic            b_clr, b_dig, b_dp, b_neg;
`ifdef CALC_BACKSPACE_EN
  logic            a_bksp, b_bksp;
`endif
  logic [W-1:0]    a_digits_nxt, b_digits_nxt;
  logic            a_sign_nxt, b_sign_nxt, a_has, a_has_nxt, b_has, b_has_nxt;
  logic [3:0]      a_dp_nxt;
  logic [2:0]      b_dp_nxt;
  logic [W-1:0]    disp_bcd_d;
  logic            disp_sign_d;
  logic [3:0]      disp_dp_d;
  logic            accept, is_digit, is_op;
  logic [2:0]      key_op;
  logic            unused_a_has;

  assign busy         = (state_q == ST_EXEC);
  assign key_ready    = !busy;
  assign accept       = key_valid && key_ready;
  assign is_digit     = (key_code <= 5'd9);
  assign is_op        = (key_code >= KEY_ADD) && (key_code <= KEY_POW);
  assign key_op       = 3'(key_code - KEY_ADD);
  assign unused_a_has = a_has ^ a_has_nxt;

  calc_entry_reg #(.DIGIT_NUM(DIGIT_NUM), .DP_W(4), .DP_MAX(15)) u_entry_a (
    .clk(clk), .rst_n(rst_n), .clr(a_clr), .ld(a_ld), .ld_digits(res_d), .ld_sign(res_sign_d),
    .key_digit(a_dig), .digit(key_code[3:0]), .key_dp(a_dp), .key_neg(a_neg),
`ifdef CALC_BACKSPACE_EN
    .key_bksp(a_bksp),
`endif
    .digits(operand0), .sign(operand0_sign), .dp(operand0_dp), .has(a_has),
    .digits_nxt(a_digits_nxt), .sign_nxt(a_sign_nxt), .dp_nxt(a_dp_nxt), .has_nxt(a_has_nxt)
  );

  calc_entry_reg #(.DIGIT_NUM(DIGIT_NUM), .DP_W(3), .DP_MAX(7)) u_entry_b (
    .clk(clk), .rst_n(rst_n), .clr(b_clr), .ld(1'b0), .ld_digits('0), .ld_sign(1'b0),
    .key_digit(b_dig), .digit(key_code[3:0]), .key_dp(b_dp), .key_neg(b_neg),
`ifdef CALC_BACKSPACE_EN
    .key_bksp(b_bksp),
`endif
    .digits(operand1), .sign(operand1_sign), .dp(operand1_dp), .has(b_has),
    .digits_nxt(b_digits_nxt), .sign_nxt(b_sign_nxt), .dp_nxt(b_dp_nxt), .has_nxt(b_has_nxt)
  );

  // Next-state, result capture and entry control.
  always_comb begin
    state_d    = state_q;
    op_d       = operation;
    pend_d     = pend_q;
    pend_op_d  = pend_op_q;
    cnt_d      = cnt_q;
    res_d      = res_q;
    res_sign_d = res_sign_q;
    err_d      = err;
    a_clr = 1'b0; a_ld = 1'b0; a_dig = 1'b0; a_dp = 1'b0; a_neg = 1'b0;
    b_clr = 1'b0; b_dig = 1'b0; b_dp = 1'b0; b_neg = 1'b0;
`ifdef CALC_BACKSPACE_EN
    a_bksp = 1'b0; b_bksp = 1'b0;
`endif
    if (state_q == ST_EXEC) begin
      if (cnt_q == '0) begin
        if (operation == OP_DIV && operand1 == '0) begin
          res_d      = '0;
          res_sign_d = 1'b0;
          err_d      = 1'b1;
          pend_d     = 1'b0;
          state_d    = ST_SHOW;
        end else begin
          res_d      = alu_result;
          res_sign_d = alu_result_sign;
          if (pend_q) begin
            // Chained operation: the fresh result becomes A (loaded via res_d).
            a_ld    = 1'b1;
            b_clr   = 1'b1;
            op_d    = pend_op_q;
            pend_d  = 1'b0;
            state_d = ST_ENTER_B;
          end else begin
            state_d = ST_SHOW;
          end
        end
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end else if (accept) begin
      if (key_code == KEY_CLR) begin
        a_clr      = 1'b1;
        b_clr      = 1'b1;
        res_d      = '0;
        res_sign_d = 1'b0;
        op_d       = OP_ADD;
        err_d      = 1'b0;
        pend_d     = 1'b0;
        state_d    = ST_ENTER_A;
      end else begin
        case (state_q)
          ST_ENTER_A: begin
            a_dig = is_digit;
            a_dp  = (key_code == KEY_DP);
            a_neg = (key_code == KEY_NEG);
`ifdef CALC_BACKSPACE_EN
            a_bksp = (key_code == KEY_BKSP);
`endif
            if (is_op) begin
              op_d    = key_op;
              b_clr   = 1'b1;
              state_d = ST_ENTER_B;
            end
          end
          ST_ENTER_B: begin
            b_dig = is_digit;
            b_dp  = (key_code == KEY_DP);
            b_neg = (key_code == KEY_NEG);
`ifdef CALC_BACKSPACE_EN
            b_bksp = (key_code == KEY_BKSP);
`endif
            if (is_op) begin
              if (!b_has) begin
                op_d = key_op;
              end else begin
                pend_d    = 1'b1;
                pend_op_d = key_op;
                cnt_d     = CW'(ALU_LAT - 1);
                state_d   = ST_EXEC;
              end
            end
            if (key_code == KEY_EQ && b_has) begin
              pend_d  = 1'b0;
              cnt_d   = CW'(ALU_LAT - 1);
              state_d = ST_EXEC;
            end
          end
          ST_SHOW: begin
            if (is_digit || key_code == KEY_DP) begin
              a_clr   = 1'b1;
              b_clr   = 1'b1;
              a_dig   = is_digit;
              a_dp    = (key_code == KEY_DP);
              state_d = ST_ENTER_A;
            end
            if (is_op) begin
              a_ld    = 1'b1;
              b_clr   = 1'b1;
              op_d    = key_op;
              state_d = ST_ENTER_B;
            end
            if (key_code == KEY_NEG) res_sign_d = !res_sign_q;
          end
          default: ;
        endcase
      end
    end
  end

  // Display source chosen from the upcoming state so it tracks the accepted key.
  always_comb begin
    disp_bcd_d  = disp_bcd;
    disp_sign_d = disp_sign;
    disp_dp_d   = disp_dp;
    case (state_d)
      ST_ENTER_A: begin
        disp_bcd_d = a_digits_nxt; disp_sign_d = a_sign_nxt; disp_dp_d = a_dp_nxt;
      end
      ST_ENTER_B: begin
        if (b_has_nxt) begin
          disp_bcd_d = b_digits_nxt; disp_sign_d = b_sign_nxt; disp_dp_d = {1'b0, b_dp_nxt};
        end else begin
          disp_bcd_d = a_digits_nxt; disp_sign_d = a_sign_nxt; disp_dp_d = a_dp_nxt;
        end
      end
      ST_SHOW: begin
        disp_bcd_d = res_d; disp_sign_d = res_sign_d; disp_dp_d = 4'd0;
      end
      default: ;
    endcase
  end

  // Sequencer state, result and display registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_ENTER_A;
      operation  <= OP_ADD;
      pend_q     <= 1'b0;
      pend_op_q  <= OP_ADD;
      cnt_q      <= '0;
      res_q      <= '0;
      res_sign_q <= 1'b0;
      err        <= 1'b0;
      disp_bcd   <= '0;
      disp_sign  <= 1'b0;
      disp_dp    <= '0;
    end else begin
      state_q    <= state_d;
      operation  <= op_d;
      pend_q     <= pend_d;
      pend_op_q  <= pend_op_d;
      cnt_q      <= cnt_d;
      res_q      <= res_d;
      res_sign_q <= res_sign_d;
      err        <= err_d;
      disp_bcd   <= disp_bcd_d;
      disp_sign  <= disp_sign_d;
      disp_dp    <= disp_dp_d;
    end
  end

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// tb_calc_seq_ctrl: directed and random key sequences checked against a
// digit-list model of the calculator sequencer.
module tb_calc_seq_ctrl;

  localparam int DN  = 8;
  localparam int LAT = 2;
  localparam int M_A = 0, M_B = 1, M_E = 2, M_S = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          key_valid = 1'b0;
  logic [4:0]    key_code = 5'd0;
  logic          key_ready;
  logic          operand0_sign, operand1_sign;
  logic [31:0]   operand0, operand1;
  logic [3:0]    operand0_dp;
  logic [2:0]    operand1_dp;
  logic [2:0]    operation;
  logic [31:0]   alu_result = 32'd0;
  logic          alu_result_sign = 1'b0;
  logic [31:0]   disp_bcd;
  logic          disp_sign;
  logic [3:0]    disp_dp;
  logic          busy, err;

  int n_chk = 0;
  int n_fail = 0;
  int busy_cycles;

  // Model: per entry a list of significant digits, dp flag/count, sign, touched flag.
  int ed[2][8];
  int en[2];
  bit eds[2];
  int edp[2];
  bit es[2];
  bit eh[2];
  int mst, mop, mpop;
  bit mpend, merr, mrs;
  logic [31:0] mres, md_bcd;
  bit md_s;
  int md_dp;

  calc_seq_ctrl #(.DIGIT_NUM(DN), .ALU_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code), .key_ready(key_ready),
    .operand0_sign(operand0_sign), .operand0(operand0), .operand0_dp(operand0_dp),
    .operand1_sign(operand1_sign), .operand1(operand1), .operand1_dp(operand1_dp),
    .operation(operation), .alu_result(alu_result), .alu_result_sign(alu_result_sign),
    .disp_bcd(disp_bcd), .disp_sign(disp_sign), .disp_dp(disp_dp), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_clear(input int e);
    en[e] = 0; eds[e] = 0; edp[e] = 0; es[e] = 0; eh[e] = 0;
  endtask

  function automatic logic [31:0] m_val(input int e);
    logic [31:0] v;
    v = 0;
    for (int i = 0; i < en[e]; i++) v = (v << 4) | 32'(ed[e][i]);
    return v;
  endfunction

  task automatic m_digit(input int e, input int d);
    int mx;
    mx = (e == 1) ? 7 : 99;
    eh[e] = 1;
    if (en[e] < DN && !(eds[e] && edp[e] == mx) && (en[e] > 0 || d > 0 || eds[e])) begin
      ed[e][en[e]] = d;
      en[e]++;
      if (eds[e]) edp[e]++;
    end
  endtask

  task automatic m_load_a(input logic [31:0] v, input bit s);
    int nib;
    m_clear(0);
    eh[0] = 1;
    es[0] = s;
    for (int i = DN - 1; i >= 0; i--) begin
      nib = int'((v >> (4 * i)) & 32'hF);
      if (en[0] > 0 || nib != 0) begin
        ed[0][en[0]] = nib;
        en[0]++;
      end
    end
  endtask

  task automatic m_disp();
    if (mst == M_S) begin
      md_bcd = mres; md_s = mrs; md_dp = 0;
    end else if (mst == M_B && eh[1]) begin
      md_bcd = m_val(1); md_s = es[1]; md_dp = edp[1];
    end else if (mst != M_E) begin
      md_bcd = m_val(0); md_s = es[0]; md_dp = edp[0];
    end
  endtask

  task automatic m_reset();
    m_clear(0); m_clear(1);
    mst = M_A; mop = 0; mpop = 0; mpend = 0; merr = 0; mrs = 0; mres = 0;
    md_bcd = 0; md_s = 0; md_dp = 0;
  endtask

  task automatic m_key(input int k);
    int e;
    if (k == 18) begin
      m_clear(0); m_clear(1);
      mres = 0; mrs = 0; mop = 0; merr = 0; mpend = 0; mst = M_A;
    end else if (k <= 10) begin
      if (mst == M_S) begin
        m_clear(0); m_clear(1); mst = M_A;
      end
      e = (mst == M_B) ? 1 : 0;
      if (k == 10) begin
        eh[e] = 1; eds[e] = 1;
      end else begin
        m_digit(e, k);
      end
    end else if (k == 11) begin
      if (mst == M_S) mrs = !mrs;
      else begin
        e = (mst == M_B) ? 1 : 0;
        es[e] = !es[e];
      end
    end else if (k >= 12 && k <= 16) begin
      if (mst == M_A) begin
        mop = k - 12; m_clear(1); mst = M_B;
      end else if (mst == M_B) begin
        if (!eh[1]) mop = k - 12;
        else begin
          mst = M_E; mpend = 1; mpop = k - 12;
        end
      end else if (mst == M_S) begin
        m_load_a(mres, mrs); m_clear(1); mop = k - 12; mst = M_B;
      end
    end else if (k == 17) begin
      if (mst == M_B && eh[1]) begin
        mst = M_E; mpend = 0;
      end
    end
    m_disp();
  endtask

  task automatic m_exec_done();
    if (mop == 3 && m_val(1) == 0) begin
      mres = 0; mrs = 0; merr = 1; mpend = 0; mst = M_S;
    end else begin
      mres = alu_result; mrs = alu_result_sign;
      if (mpend) begin
        m_load_a(mres, mrs); m_clear(1); mop = mpop; mpend = 0; mst = M_B;
      end else begin
        mst = M_S;
      end
    end
    m_disp();
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".operand0"}, operand0, m_val(0));
    chk({tag, ".operand0_sign"}, operand0_sign, es[0]);
    chk({tag, ".operand0_dp"}, operand0_dp, edp[0]);
    chk({tag, ".operand1"}, operand1, m_val(1));
    chk({tag, ".operand1_sign"}, operand1_sign, es[1]);
    chk({tag, ".operand1_dp"}, operand1_dp, edp[1]);
    chk({tag, ".operation"}, operation, mop);
    chk({tag, ".disp_bcd"}, disp_bcd, md_bcd);
    chk({tag, ".disp_sign"}, disp_sign, md_s);
    chk({tag, ".disp_dp"}, disp_dp, md_dp);
    chk({tag, ".err"}, err, merr);
    chk({tag, ".busy"}, busy, (mst == M_E));
    chk({tag, ".key_ready"}, key_ready, (mst != M_E));
  endtask

  task automatic run_exec();
    busy_cycles = 1;
    for (int i = 1; i < LAT; i++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
      check_all("exec");
    end
    @(negedge clk);
    if (busy) busy_cycles++;
    m_exec_done();
    check_all("post_exec");
  endtask

  task automatic press(input int k, input bit do_exec);
    int n;
    n = 0;
    @(negedge clk);
    while (!key_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", key_ready, 1'b1);
    key_valid = 1'b1;
    key_code  = 5'(k);
    @(negedge clk);
    key_valid = 1'b0;
    m_key(k);
    check_all("key");
    if (do_exec && mst == M_E) run_exec();
  endtask

  function automatic logic [31:0] rand_bcd();
    logic [31:0] v;
    v = 0;
    for (int i = 0; i < DN; i++) v = (v << 4) | 32'($urandom_range(0, 9));
    return v;
  endfunction

  initial begin
    int r, k;
    m_reset();
    #1;
    check_all("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 12.5 + 3 with a fixed ALU answer.
    press(1, 1); press(2, 1); press(10, 1); press(5, 1); press(12, 1); press(3, 1);
    alu_result = 32'h00001550; alu_result_sign = 1'b0;
    press(17, 0);
    chk("t1.operand0", operand0, 32'h125);
    chk("t1.operand0_dp", operand0_dp, 4'd1);
    chk("t1.operand1", operand1, 32'h3);
    chk("t1.operation", operation, 3'd0);
    chk("t1.key_ready", key_ready, 1'b0);
    run_exec();
    chk("t1.busy_cycles", busy_cycles, LAT);
    chk("t1.disp_bcd", disp_bcd, 32'h1550);

    // Digit limit.
    press(18, 1);
    for (int i = 0; i < 10; i++) press(9, 1);
    chk("t2.operand0", operand0, 32'h99999999);

    // Divide by zero, then clear.
    press(8, 1); press(18, 1);
    press(8, 1); press(15, 1); press(0, 1); press(17, 1);
    chk("t3.err", err, 1'b1);
    chk("t3.disp_bcd", disp_bcd, 32'h0);
    press(18, 1);
    chk("t3.err_clr", err, 1'b0);

    // Chained operation.
    press(2, 1); press(12, 1); press(3, 1);
    alu_result = 32'h00000005; alu_result_sign = 1'b0;
    press(14, 1);
    chk("t4.operand0", operand0, 32'h5);
    chk("t4.operation", operation, 3'd2);
    alu_result = 32'h00000020;
    press(4, 1); press(17, 1);
    chk("t4.disp_bcd", disp_bcd, 32'h20);

    // Sign toggles and op replacement with empty B.
    press(18, 1);
    press(5, 1); press(11, 1); press(11, 1); press(11, 1);
    chk("t5.sign", operand0_sign, 1'b1);
    press(12, 1); press(13, 1); press(14, 1);
    chk("t5.operation", operation, 3'd2);

    // Reset during EXEC.
    press(6, 1);
    press(17, 0);
    chk("t6.busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    m_reset();
    check_all("t6.reset");
    @(negedge clk);
    rst_n = 1'b1;
    press(7, 1);
    chk("t6.operand0", operand0, 32'h7);

    // Random key stream.
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 45)      k = $urandom_range(0, 9);
      else if (r < 51) k = 10;
      else if (r < 57) k = 11;
      else if (r < 72) k = $urandom_range(12, 16);
      else if (r < 88) k = 17;
      else if (r < 91) k = 18;
      else begin
`ifdef CALC_BACKSPACE_EN
        k = $urandom_range(20, 31);
`else
        k = $urandom_range(19, 31);
`endif
      end
      alu_result      = rand_bcd();
      alu_result_sign = 1'($urandom_range(0, 1));
      press(k, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/calc_seq_ctrl.md
Name: calc_seq_ctrl

Overview:
- Keypad-driven sequencer for the 8-digit BCD calculator ALU (add/sub/mul/div/pow).
- Accepts one key event per handshake and builds operand A and operand B in BCD, each with a sign and a decimal-point count.
- Issues the operation to the combinational ALU, waits a fixed settle time, captures the result, and drives the display registers.
- Sits between the keypad decoder and the ALU/display driver.

Parameters:
- DIGIT_NUM, 8: BCD digits per operand; bus width is DIGIT_NUM*4.
- ALU_LAT, 2: cycles the operands are held stable before the result is captured (min 1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- key_valid  in  1  key event present.
- key_code  in  5  0-9 digit, 10 dp, 11 neg, 12 add, 13 sub, 14 mul, 15 div, 16 pow, 17 equals, 18 clear.
- key_ready  out  1  key accepted when key_valid&&key_ready.
- operand0_sign / operand0 / operand0_dp  out  1 / DIGIT_NUM*4 / 4  A to ALU.
- operand1_sign / operand1 / operand1_dp  out  1 / DIGIT_NUM*4 / 3  B to ALU.
- operation  out  3  0 add, 1 sub, 2 mul, 3 div, 4 pow.
- alu_result  in  DIGIT_NUM*4  ALU BCD result.
- alu_result_sign  in  1  ALU result sign.
- disp_bcd / disp_sign / disp_dp  out  DIGIT_NUM*4 / 1 / 4  display value.
- busy  out  1  high in EXEC.
- err  out  1  sticky divide-by-zero flag.

Behaviour:
- Reset (async, rst_n low): all outputs 0, key_ready=1, state ENTER_A, both entries cleared.
- States: ENTER_A, ENTER_B, EXEC, SHOW. key_ready=!busy; busy=1 only in EXEC.
- Digit key:
  - Current entry shifts left 4 bits; the digit enters the low nibble.
  - Ignored once the entry holds DIGIT_NUM digits.
  - Leading zeros do not count as digits until a nonzero digit or dp arrives.
  - After dp, each accepted digit increments dp. B saturates at dp=7: further digits are ignored.
- dp key: sets dp_seen; a second dp in the same entry is ignored.
- neg key: toggles the sign of the current entry.
- ENTER_A:
  - op key latches operation, clears B, goes to ENTER_B.
  - equals is ignored.
- ENTER_B:
  - op key with B empty (0 digits): replaces the latched operation.
  - op key with B non-empty: chained; goes to EXEC and remembers the new op as pending.
  - equals with B non-empty: goes to EXEC. equals with B empty: ignored.
- EXEC:
  - Operands and operation are held constant; keys are stalled.
  - A down-counter is loaded with ALU_LAT-1. At 0, alu_result/alu_result_sign are registered into the result register.
  - Exit: to SHOW, or to ENTER_B with A := result (dp 0) if an op is pending.
  - Divide-by-zero (operation==div, operand1==0): no capture, result:=0, err:=1, pending op dropped, go to SHOW.
- SHOW:
  - Digit or dp key: clears A and B, starts a new A, goes to ENTER_A, and applies the key.
  - Op key: A := result (sign kept, dp 0), latches op, goes to ENTER_B.
  - neg key: toggles the result sign. equals key: ignored.
- clear key (any non-EXEC state): resets entries, result, operation and err; goes to ENTER_A. clear during EXEC stalls like any key and is accepted after EXEC.
- err: clears only on clear key or reset.
- Display mux:
  - ENTER_A: A.
  - ENTER_B: B if non-empty, else A.
  - EXEC: previous display held.
  - SHOW: result.
  - Registered; updates the cycle after key acceptance.
- Latency: equals accepted at cycle t → busy t+1..t+ALU_LAT → SHOW and display valid at t+ALU_LAT+1.
- Reset mid-EXEC: immediate return to reset values; no capture.

Optional Feature:
- Macro CALC_BACKSPACE_EN.
- Defined: key_code 19 in ENTER_A/ENTER_B shifts the current entry right 4 bits and decrements the digit count. If the removed digit was fractional, dp decrements. If dp reaches 0 with dp_seen set, dp_seen clears first. Ignored on an empty entry and in SHOW.
- Undefined: code 19 is treated like codes 20-31: accepted and discarded, no state change.

Decomposition:
- Package calc_pkg: key-code constants, operation encodings (OP_ADD..OP_POW), state enum, DIGIT_NUM default.
- Sub-module calc_entry_reg: one operand entry (digits, count, dp_seen, dp, sign; load/clear/shift ports), instantiated for A and B. The dp width limit is a parameter.

Test Plan:
- Keys 1,2,dp,5,add,3,equals; ALU model returns 0x00001550 → result captured after exactly ALU_LAT cycles. Checks during EXEC: operand0=0x125, operand0_dp=1, operand1=0x3, operation=0, busy high for 2 cycles, key_ready low.
- Keys 9×10 → operand0=0x99999999: 9th and 10th digits are ignored.
- Keys 8,div,0,equals → no capture, err=1, disp_bcd=0, SHOW. Then key clear → err=0, ENTER_A.
- Keys 2,add,3,mul (chain) → EXEC with add; then A=result, operation=2, state ENTER_B. Then 4,equals → EXEC with mul.
- Keys 5,neg,neg,neg → operand0_sign=1. Then add,sub,mul → operation=2 with B still empty.
- rst_n pulsed low mid-EXEC → all outputs zero immediately, key_ready=1; a subsequent digit 7 gives operand0=0x7.
